// File: rtl/cv32e40p_tmr_voter_seq.sv
// Registered TMR voter with per-replica fault tracking and TMR -> DMR -> HALT degradation.
// Optional cumulative error counters are enabled with CV32E40P_VOTER_ERR_CNT_EN.
module cv32e40p_tmr_voter_seq #(
    parameter int NBIT         = 32,
    parameter int FAULT_THRESH = 4,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [NBIT-1:0]   data1_i,
    input  logic [NBIT-1:0]   data2_i,
    input  logic [NBIT-1:0]   data3_i,
    input  logic              clear_i,
    output logic [NBIT-1:0]   dataout_o,
    output logic              valid_o,
    output logic              mismatch_o,
    output logic [2:0]        minority_o,
    output logic [2:0]        fail_o,
    output logic              uncorr_o,
    output logic [1:0]        mode_o,
    output logic [3*CNT_W-1:0] err_cnt_o
);

    typedef enum logic [1:0] {
        MODE_TMR  = 2'b00,
        MODE_DMR  = 2'b01,
        MODE_HALT = 2'b10
    } mode_e;

    localparam logic [3:0] THR = FAULT_THRESH[3:0];

    mode_e           r_mode, w_mode_nxt;
    logic [2:0]      r_fail, w_fail_nxt;
    logic [2:0][3:0] r_cons, w_cons_nxt;

    logic [NBIT-1:0] r_data;
    logic            r_valid, r_mismatch, r_uncorr;
    logic [2:0]      r_minority;

    logic            w_eq12, w_eq13, w_eq23;
    logic [NBIT-1:0] w_vote, w_lo, w_hi;
    logic [2:0]      w_min;
    logic            w_mm, w_unc;

    assign w_eq12 = (data1_i == data2_i);
    assign w_eq13 = (data1_i == data3_i);
    assign w_eq23 = (data2_i == data3_i);

    // Healthy pair for DMR/HALT; lower index first.
    always_comb begin
        w_lo = data1_i;
        w_hi = data2_i;
        if (r_fail[0]) begin
            w_lo = data2_i;
            w_hi = data3_i;
        end else if (r_fail[1]) begin
            w_hi = data3_i;
        end
    end

    // A clearing vote uses full TMR rules even if the current mode is degraded.
    always_comb begin
        w_vote = data1_i;
        w_min  = 3'b000;
        w_mm   = 1'b0;
        w_unc  = 1'b0;
        if (clear_i || r_mode == MODE_TMR) begin
            if (w_eq12 && w_eq13) begin
                w_mm = 1'b0;
            end else if (w_eq12) begin
                w_min = 3'b100;
                w_mm  = 1'b1;
            end else if (w_eq13) begin
                w_min = 3'b010;
                w_mm  = 1'b1;
            end else if (w_eq23) begin
                w_vote = data2_i;
                w_min  = 3'b001;
                w_mm   = 1'b1;
            end else begin
                w_mm  = 1'b1;
                w_unc = 1'b1;
            end
        end else begin
            w_vote = w_lo;
            w_mm   = (w_lo != w_hi);
            w_unc  = (w_lo != w_hi);
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        w_fail_nxt = r_fail;
        w_cons_nxt = r_cons;
        if (clear_i) begin
            w_mode_nxt = MODE_TMR;
            w_fail_nxt = 3'b000;
            w_cons_nxt = '0;
        end else if (valid_i && r_mode == MODE_TMR && !w_unc) begin
            for (int k = 0; k < 3; k++) begin
                if (w_min[k]) begin
                    if (r_cons[k] + 4'd1 >= THR) begin
                        w_cons_nxt[k] = THR;
                        w_fail_nxt[k] = 1'b1;
                        w_mode_nxt    = MODE_DMR;
                    end else begin
                        w_cons_nxt[k] = r_cons[k] + 4'd1;
                    end
                end else begin
                    w_cons_nxt[k] = 4'd0;
                end
            end
        end else if (valid_i && r_mode == MODE_DMR && w_unc) begin
            w_mode_nxt = MODE_HALT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= MODE_TMR;
            r_fail     <= 3'b000;
            r_cons     <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_mismatch <= 1'b0;
            r_minority <= 3'b000;
            r_uncorr   <= 1'b0;
        end else begin
            r_mode  <= w_mode_nxt;
            r_fail  <= w_fail_nxt;
            r_cons  <= w_cons_nxt;
            r_valid <= valid_i;
            if (valid_i) begin
                r_data     <= w_vote;
                r_mismatch <= w_mm;
                r_minority <= w_min;
                r_uncorr   <= w_unc;
            end else begin
                r_mismatch <= 1'b0;
                r_minority <= 3'b000;
                r_uncorr   <= 1'b0;
            end
        end
    end

`ifdef CV32E40P_VOTER_ERR_CNT_EN
    logic [2:0][CNT_W-1:0] r_err;

    // Clearing votes are not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= '0;
        end else if (valid_i && !clear_i) begin
            for (int k = 0; k < 3; k++) begin
                if (w_min[k] && r_err[k] != {CNT_W{1'b1}}) r_err[k] <= r_err[k] + 1'b1;
            end
        end
    end

    assign err_cnt_o = r_err;
`else
    assign err_cnt_o = '0;
`endif

    assign dataout_o  = r_data;
    assign valid_o    = r_valid;
    assign mismatch_o = r_mismatch;
    assign minority_o = r_minority;
    assign fail_o     = r_fail;
    assign uncorr_o   = r_uncorr;
    assign mode_o     = r_mode;

endmodule

// File: tb/tb_cv32e40p_tmr_voter_seq.sv
// Directed table-driven bench for cv32e40p_tmr_voter_seq plus hand sequences for
// reset mid-operation and error counter saturation.
module tb_cv32e40p_tmr_voter_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        valid_i = 1'b0, clear_i = 1'b0;
    logic [31:0] data1_i = '0, data2_i = '0, data3_i = '0;
    logic [31:0] dataout_o;
    logic        valid_o, mismatch_o, uncorr_o;
    logic [2:0]  minority_o, fail_o;
    logic [1:0]  mode_o;
    logic [23:0] err_cnt_o;

    logic        v2 = 1'b0, c2 = 1'b0;
    logic [31:0] a2 = '0, b2 = '0, d2 = '0;
    logic [31:0] out2;
    logic        vo2, mm2, unc2;
    logic [2:0]  min2, fail2;
    logic [1:0]  mode2;
    logic [5:0]  err2;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    cv32e40p_tmr_voter_seq #(.NBIT(32), .FAULT_THRESH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i),
        .data1_i(data1_i), .data2_i(data2_i), .data3_i(data3_i), .clear_i(clear_i),
        .dataout_o(dataout_o), .valid_o(valid_o), .mismatch_o(mismatch_o),
        .minority_o(minority_o), .fail_o(fail_o), .uncorr_o(uncorr_o),
        .mode_o(mode_o), .err_cnt_o(err_cnt_o)
    );

    cv32e40p_tmr_voter_seq #(.NBIT(32), .FAULT_THRESH(15), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .valid_i(v2),
        .data1_i(a2), .data2_i(b2), .data3_i(d2), .clear_i(c2),
        .dataout_o(out2), .valid_o(vo2), .mismatch_o(mm2),
        .minority_o(min2), .fail_o(fail2), .uncorr_o(unc2),
        .mode_o(mode2), .err_cnt_o(err2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, c;
        logic [31:0] d1, d2, d3;
        logic [31:0] e_data;
        logic        e_vo, e_mm;
        logic [2:0]  e_min, e_fail;
        logic        e_unc;
        logic [1:0]  e_mode;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic c, input logic [31:0] x1, input logic [31:0] x2,
                       input logic [31:0] x3, input logic [31:0] ed, input logic evo, input logic emm,
                       input logic [2:0] emin, input logic [2:0] efail, input logic eunc,
                       input logic [1:0] emode);
        vec_t t;
        t.v = v; t.c = c; t.d1 = x1; t.d2 = x2; t.d3 = x3;
        t.e_data = ed; t.e_vo = evo; t.e_mm = emm; t.e_min = emin;
        t.e_fail = efail; t.e_unc = eunc; t.e_mode = emode;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [42:0] pack1();
        return {dataout_o, valid_o, mismatch_o, minority_o, fail_o, uncorr_o, mode_o};
    endfunction

    initial begin
        logic [23:0] e_err;
        logic [5:0]  e_err2;

        // all equal
        for (int i = 0; i < 3; i++)
            add(1, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1, 0, 3'b000, 3'b000, 0, 2'b00);
        add(0, 0, 0, 0, 0, 32'hA5A5A5A5, 0, 0, 3'b000, 3'b000, 0, 2'b00);
        // replica 2 outvoted until it fails
        for (int i = 0; i < 3; i++)
            add(1, 0, 0, 1, 0, 0, 1, 1, 3'b010, 3'b000, 0, 2'b00);
        add(1, 0, 0, 1, 0, 0, 1, 1, 3'b010, 3'b010, 0, 2'b01);
        // DMR: agree, then disagree -> HALT
        add(1, 0, 7, 9, 7, 7, 1, 0, 3'b000, 3'b010, 0, 2'b01);
        add(1, 0, 5, 0, 6, 5, 1, 1, 3'b000, 3'b010, 1, 2'b10);
        add(1, 0, 3, 3, 3, 3, 1, 0, 3'b000, 3'b010, 0, 2'b10);
        add(1, 0, 8, 3, 9, 8, 1, 1, 3'b000, 3'b010, 1, 2'b10);
        add(0, 1, 0, 0, 0, 8, 0, 0, 3'b000, 3'b000, 0, 2'b00);
        // TMR, all differ
        add(1, 0, 1, 2, 3, 1, 1, 1, 3'b000, 3'b000, 1, 2'b00);
        // replica 3: 2 minority, uncorrectable (no change), 1 minority, agree, 4 minority
        add(1, 0, 4, 4, 5, 4, 1, 1, 3'b100, 3'b000, 0, 2'b00);
        add(1, 0, 4, 4, 5, 4, 1, 1, 3'b100, 3'b000, 0, 2'b00);
        add(1, 0, 6, 7, 8, 6, 1, 1, 3'b000, 3'b000, 1, 2'b00);
        add(1, 0, 4, 4, 5, 4, 1, 1, 3'b100, 3'b000, 0, 2'b00);
        add(1, 0, 4, 4, 4, 4, 1, 0, 3'b000, 3'b000, 0, 2'b00);
        for (int i = 0; i < 3; i++)
            add(1, 0, 4, 4, 5, 4, 1, 1, 3'b100, 3'b000, 0, 2'b00);
        add(1, 0, 4, 4, 5, 4, 1, 1, 3'b100, 3'b100, 0, 2'b01);
        // clear with valid: TMR vote, no count; then replica 1 needs 4 more to fail
        add(1, 1, 1, 2, 2, 2, 1, 1, 3'b001, 3'b000, 0, 2'b00);
        for (int i = 0; i < 3; i++)
            add(1, 0, 1, 2, 2, 2, 1, 1, 3'b001, 3'b000, 0, 2'b00);
        add(1, 0, 1, 2, 2, 2, 1, 1, 3'b001, 3'b001, 0, 2'b01);

        repeat (2) @(negedge clk);
        check("reset_outputs", {pack1(), err_cnt_o}, '0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            valid_i = vecs[i].v; clear_i = vecs[i].c;
            data1_i = vecs[i].d1; data2_i = vecs[i].d2; data3_i = vecs[i].d3;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), pack1(),
                  {vecs[i].e_data, vecs[i].e_vo, vecs[i].e_mm, vecs[i].e_min,
                   vecs[i].e_fail, vecs[i].e_unc, vecs[i].e_mode});
        end

`ifdef CV32E40P_VOTER_ERR_CNT_EN
        e_err = {8'd7, 8'd4, 8'd4};
`else
        e_err = '0;
`endif
        check("err_cnt_cumulative", err_cnt_o, e_err);

        // asynchronous reset between edges drops pending outputs and state
        @(negedge clk);
        valid_i = 1'b1; clear_i = 1'b0;
        data1_i = 32'h11; data2_i = 32'h11; data3_i = 32'h11;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("reset_midop", {pack1(), err_cnt_o}, '0);
        @(negedge clk);
        valid_i = 1'b0;
        rst = 1'b0;

        // CNT_W=2 counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            v2 = 1'b1; a2 = 32'h1; b2 = 32'h0; d2 = 32'h0;
            @(posedge clk);
            #1;
`ifdef CV32E40P_VOTER_ERR_CNT_EN
            e_err2 = {4'd0, (i < 3) ? 2'(i + 1) : 2'd3};
`else
            e_err2 = '0;
`endif
            check($sformatf("sat_cnt%0d", i), {out2, min2, fail2, mode2, err2},
                  {32'h0, 3'b001, 3'b000, 2'b00, e_err2});
        end
        @(negedge clk);
        v2 = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
